// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// slave = arbiter view; master = the requesters plus the transmit-data block.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ack;
    logic [N_REQ-1:0]   grant;
    logic               txdStart;
    logic [7:0]         data;
    logic               txdBusy;

    modport slave (
        input  req, req_data, req_last, txdBusy,
        output req_ack, grant, txdStart, data
    );

    modport master (
        output req, req_data, req_last, txdBusy,
        input  req_ack, grant, txdStart, data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one byte-serial UART transmitter.
// Define UART_TX_GAP_EN to add GAP_CYCLES of idle spacing between bytes.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus,
    output logic             busy,
    output logic             timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    if (N_REQ < 2 || N_REQ > 8 || BUSY_TIMEOUT < 2 || GAP_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_END
`ifdef UART_TX_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   req_ack_q, req_ack_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic               txd_start_q, txd_start_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timeout_err_q, timeout_err_d;
    logic               busy_q, busy_d;
    logic               msg_done;

`ifdef UART_TX_GAP_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               gap_idle_q, gap_idle_d;
`endif

    // First requester with req set, searching upward from ptr+1 with wrap-around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(p) + k) % N_REQ;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // An abandoned message (req dropped) ends exactly like one that sent its last byte.
    assign msg_done = last_q || !bus.req[winner_q];

    always_comb begin
        // NOTE: every _d gets its hold value first so no branch can infer a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        winner_d      = winner_q;
        grant_d       = grant_q;
        data_d        = data_q;
        last_d        = last_q;
        timer_d       = timer_q;
        timeout_err_d = timeout_err_q;
        txd_start_d   = 1'b0;
        req_ack_d     = '0;
`ifdef UART_TX_GAP_EN
        gap_cnt_d     = gap_cnt_q;
        gap_idle_d    = gap_idle_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    winner_d = rr_pick(bus.req, ptr_q);
                    grant_d  = N_REQ'(1) << rr_pick(bus.req, ptr_q);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!bus.req[winner_q]) begin
                    ptr_d   = winner_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else if (!bus.txdBusy) begin
                    data_d      = bus.req_data[8*winner_q +: 8];
                    last_d      = bus.req_last[winner_q];
                    txd_start_d = 1'b1;
                    req_ack_d   = grant_q;
                    state_d     = S_START;
                end
            end
            S_START: begin
                // timer counts cycles since the start pulse; START itself is the first.
                timer_d = TMR_W'(1);
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.txdBusy) begin
                    state_d = S_WAIT_LO;
                end else if (timer_q >= TMR_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_END;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!bus.txdBusy) state_d = S_END;
            end
            S_END: begin
                if (msg_done) begin
                    ptr_d   = winner_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LOAD;
                end
`ifdef UART_TX_GAP_EN
                // END is the first idle cycle of the gap; GAP supplies the rest.
                if (GAP_CYCLES > 1) begin
                    gap_idle_d = msg_done;
                    gap_cnt_d  = GAP_W'(1);
                    state_d    = S_GAP;
                end
`endif
            end
`ifdef UART_TX_GAP_EN
            S_GAP: begin
                if (gap_cnt_q >= GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = gap_idle_q ? S_IDLE : S_LOAD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
`endif
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= IDX_W'(N_REQ - 1);
            winner_q      <= '0;
            grant_q       <= '0;
            req_ack_q     <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            txd_start_q   <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_TX_GAP_EN
            gap_cnt_q     <= '0;
            gap_idle_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            winner_q      <= winner_d;
            grant_q       <= grant_d;
            req_ack_q     <= req_ack_d;
            data_q        <= data_d;
            last_q        <= last_d;
            txd_start_q   <= txd_start_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
`ifdef UART_TX_GAP_EN
            gap_cnt_q     <= gap_cnt_d;
            gap_idle_q    <= gap_idle_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.req_ack  = req_ack_q;
    assign bus.txdStart = txd_start_q;
    assign bus.data     = data_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue requesters, a busy-for-N-cycles
// transmitter model, and hand-computed expectations for order, data and timing.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BT       = 16;
    localparam int GC       = 4;
    localparam int BUSY_LEN = 10;
`ifdef UART_TX_GAP_EN
    localparam int GAP_EXTRA = GC - 1;
`else
    localparam int GAP_EXTRA = 0;
`endif
    // txdBusy fall -> next txdStart: END, LOAD, START (same message); plus IDLE otherwise.
    localparam int SAME_GAP = 3 + GAP_EXTRA;
    localparam int NEXT_GAP = 4 + GAP_EXTRA;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();
    logic busy;
    logic timeout_err;

    uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(BT), .GAP_CYCLES(GC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Requester byte queues: main appends (q_len), the model pops on req_ack (q_head).
    logic [7:0] q_data [N][16];
    logic       q_last [N][16];
    int         q_len  [N] = '{default: 0};
    int         q_head [N] = '{default: 0};

    logic [N-1:0]   req_r      = '0;
    logic [8*N-1:0] req_data_r = '0;
    logic [N-1:0]   req_last_r = '0;
    logic           txd_busy_r = 1'b0;
    assign bus.req      = req_r;
    assign bus.req_data = req_data_r;
    assign bus.req_last = req_last_r;
    assign bus.txdBusy  = txd_busy_r;

    logic force_busy = 1'b0;
    logic never_busy = 1'b0;

    int         cyc       = 0;
    int         own_cnt   = 0;
    logic       own_busy  = 1'b0;
    logic       busy_prev = 1'b0;
    int         fall_cyc  = -100;
    logic       err_prev  = 1'b0;
    int         to_cyc    = -1;
    int         ack_cnt [N] = '{default: 0};
    int         st_cyc[$];
    logic [7:0] st_data[$];
    logic [N-1:0] st_grant[$];
    int         st_gap[$];

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester and transmitter models, sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (bus.req_ack[i]) begin
                ack_cnt[i]++;
                if (q_head[i] < q_len[i]) q_head[i]++;
            end
        end
        for (int i = 0; i < N; i++) begin
            req_r[i] = (q_head[i] < q_len[i]);
            req_data_r[8*i +: 8] = req_r[i] ? q_data[i][q_head[i]] : 8'h00;
            req_last_r[i]        = req_r[i] ? q_last[i][q_head[i]] : 1'b0;
        end
        if (own_cnt > 0) begin
            own_cnt--;
            if (own_cnt == 0) own_busy = 1'b0;
        end
        if (bus.txdStart) begin
            st_cyc.push_back(cyc);
            st_data.push_back(bus.data);
            st_grant.push_back(bus.grant);
            st_gap.push_back(cyc - fall_cyc);
            if (!never_busy) begin
                own_cnt  = BUSY_LEN;
                own_busy = 1'b1;
            end
        end
        txd_busy_r = own_busy | force_busy;
        if (busy_prev && !txd_busy_r) fall_cyc = cyc;
        busy_prev = txd_busy_r;
        if (timeout_err && !err_prev) to_cyc = cyc;
        err_prev = timeout_err;
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        q_data[i][q_len[i]] = d;
        q_last[i][q_len[i]] = l;
        q_len[i]++;
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (q_head[i] < q_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
            done = (busy == 1'b0) && queues_empty() && (txd_busy_r == 1'b0);
        end
        check({tag, "_idle_reached"}, 32'(done), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int i, input int target, input int max_cyc);
        int n;
        n = 0;
        while (ack_cnt[i] < target && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, 32'(ack_cnt[i] >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},   32'(bus.grant),    32'd0);
        check({tag, "_ack"},     32'(bus.req_ack),  32'd0);
        check({tag, "_start"},   32'(bus.txdStart), 32'd0);
        check({tag, "_data"},    32'(bus.data),     32'd0);
        check({tag, "_busy"},    32'(busy),         32'd0);
        check({tag, "_timeout"}, 32'(timeout_err),  32'd0);
    endtask

    int base;
    int a0, a1, a2, a3;
    int exp_req;

    initial begin
        #1 reset = 1'b1;
        #2 check_reset_outputs("rst0");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single requester, three-byte message.
        base = st_data.size();
        a0   = ack_cnt[0];
        push(0, 8'h31, 1'b0);
        push(0, 8'h32, 1'b0);
        push(0, 8'h33, 1'b1);
        wait_idle("t1", 300);
        check("t1_nstart", 32'(st_data.size() - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t1_data%0d", k),  32'(st_data[base+k]),  32'(8'h31 + k));
            check($sformatf("t1_grant%0d", k), 32'(st_grant[base+k]), 32'b0001);
        end
        check("t1_gap1", 32'(st_gap[base+1]), 32'(SAME_GAP));
        check("t1_gap2", 32'(st_gap[base+2]), 32'(SAME_GAP));
        check("t1_acks", 32'(ack_cnt[0] - a0), 32'd3);
        check("t1_grant_end", 32'(bus.grant), 32'd0);
        check("t1_busy_end",  32'(busy),      32'd0);

        // Fresh reset, all four request two one-byte messages each.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        base = st_data.size();
        for (int i = 0; i < N; i++) begin
            push(i, 8'h40 + 8'(i), 1'b1);
            push(i, 8'h50 + 8'(i), 1'b1);
        end
        wait_idle("t2", 800);
        check("t2_nstart", 32'(st_data.size() - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            exp_req = k % N;
            check($sformatf("t2_grant%0d", k), 32'(st_grant[base+k]), 32'(1 << exp_req));
            check($sformatf("t2_data%0d", k),  32'(st_data[base+k]),
                  32'(((k < N) ? 8'h40 : 8'h50) + 8'(exp_req)));
            if (k > 0) check($sformatf("t2_gap%0d", k), 32'(st_gap[base+k]), 32'(NEXT_GAP));
        end

        // Requester 1 arrives while requester 2 is mid-message.
        base = st_data.size();
        a2   = ack_cnt[2];
        push(2, 8'h71, 1'b0);
        push(2, 8'h72, 1'b1);
        wait_ack("t3", 2, a2 + 1, 100);
        push(1, 8'h81, 1'b1);
        wait_idle("t3", 300);
        check("t3_nstart", 32'(st_data.size() - base), 32'd3);
        check("t3_data0",  32'(st_data[base]),    32'h71);
        check("t3_grant0", 32'(st_grant[base]),   32'b0100);
        check("t3_data1",  32'(st_data[base+1]),  32'h72);
        check("t3_grant1", 32'(st_grant[base+1]), 32'b0100);
        check("t3_data2",  32'(st_data[base+2]),  32'h81);
        check("t3_grant2", 32'(st_grant[base+2]), 32'b0010);
        check("t3_gap1",   32'(st_gap[base+1]),   32'(SAME_GAP));
        check("t3_gap2",   32'(st_gap[base+2]),   32'(NEXT_GAP));

        // Abandon in LOAD while the transmitter is held busy.
        base = st_data.size();
        a0   = ack_cnt[0];
        force_busy = 1'b1;
        push(0, 8'h99, 1'b1);
        repeat (6) @(negedge clk);
        check("ab_grant_held", 32'(bus.grant), 32'b0001);
        check("ab_busy_held",  32'(busy),      32'd1);
        check("ab_no_start",   32'(st_data.size() - base), 32'd0);
        q_len[0] = q_head[0];
        repeat (4) @(negedge clk);
        check("ab_grant_rel", 32'(bus.grant), 32'd0);
        check("ab_busy_rel",  32'(busy),      32'd0);
        check("ab_no_start2", 32'(st_data.size() - base), 32'd0);
        check("ab_no_ack",    32'(ack_cnt[0] - a0), 32'd0);
        force_busy = 1'b0;
        // Abandon moved ptr to 0, so requester 1 now beats requester 0.
        push(0, 8'hA0, 1'b1);
        push(1, 8'hB1, 1'b1);
        wait_idle("ab", 300);
        check("ab_nstart", 32'(st_data.size() - base), 32'd2);
        check("ab_data0",  32'(st_data[base]),    32'hB1);
        check("ab_grant0", 32'(st_grant[base]),   32'b0010);
        check("ab_data1",  32'(st_data[base+1]),  32'hA0);
        check("ab_grant1", 32'(st_grant[base+1]), 32'b0001);

        // Transmitter never raises txdBusy.
        base = st_data.size();
        a3   = ack_cnt[3];
        never_busy = 1'b1;
        push(3, 8'h55, 1'b0);
        push(3, 8'h66, 1'b1);
        wait_idle("to", 300);
        never_busy = 1'b0;
        check("to_nstart",  32'(st_data.size() - base), 32'd2);
        check("to_delay",   32'(to_cyc - st_cyc[base]), 32'(BT));
        check("to_sticky",  32'(timeout_err), 32'd1);
        check("to_data0",   32'(st_data[base]),    32'h55);
        check("to_data1",   32'(st_data[base+1]),  32'h66);
        check("to_grant1",  32'(st_grant[base+1]), 32'b1000);
        check("to_acks",    32'(ack_cnt[3] - a3), 32'd2);

        // Reset in WAIT_LO while the transmitter keeps shifting.
        base = st_data.size();
        a1   = ack_cnt[1];
        push(1, 8'hC1, 1'b0);
        push(1, 8'hC2, 1'b1);
        wait_ack("rw", 1, a1 + 1, 100);
        repeat (4) @(negedge clk);
        force_busy = 1'b1;
        reset      = 1'b1;
        #1 check_reset_outputs("rw_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rw_no_early_start", 32'(st_data.size() - base), 32'd1);
        force_busy = 1'b0;
        wait_idle("rw", 300);
        check("rw_nstart", 32'(st_data.size() - base), 32'd2);
        check("rw_data1",  32'(st_data[base+1]),  32'hC2);
        check("rw_grant1", 32'(st_grant[base+1]), 32'b0010);
        check("rw_gap1",   32'(st_gap[base+1]),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single byte-serial UART transmitter (txdStart/data/txdBusy interface) among N_REQ requesters, e.g. keypad digit echo, result return and status messages.
- Round-robin arbitration with message locking: once granted, a requester keeps the transmitter until it sends its last byte or drops its request.
- Sits between the requesters and the transmit-data block and is the only driver of its txdStart/data inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 16, max cycles to wait for txdBusy to rise after a start pulse.
- GAP_CYCLES, 4, idle cycles between bytes; used only when UART_TX_GAP_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester byte-valid; held until acked.
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i].
- req_last  in  N_REQ  current byte of requester i ends its message.
- req_ack  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- grant  out  N_REQ  one-hot owner of transmitter; 0 when idle.
- txdStart  out  1  one-cycle start pulse to transmitter.
- data  out  8  byte to transmit, registered, stable from LOAD to the next LOAD.
- txdBusy  in  1  transmitter busy.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky: txdBusy failed to rise in time; cleared only by reset.

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, ptr = N_REQ-1 so requester 0 wins first.
- Outputs are registered; txdStart and req_ack are never combinational from inputs.
- IDLE:
  - If req != 0, select winner = first set bit searching ptr+1, ptr+2, ... with wrap-around modulo N_REQ.
  - Next cycle: state LOAD, grant = onehot(winner).
- LOAD:
  - Wait while txdBusy=1. This covers reset asserted mid-frame with the transmitter still shifting.
  - When txdBusy=0: data <= req_data[winner], last_q <= req_last[winner], state START.
- START: exactly one cycle.
  - txdStart=1 and req_ack[winner]=1 in the same cycle.
  - Next state WAIT_HI, timer cleared.
- WAIT_HI:
  - txdBusy=1 -> WAIT_LO.
  - Timer reaching BUSY_TIMEOUT -> set timeout_err and treat the byte as sent (go to END).
- WAIT_LO: txdBusy=0 -> END.
- END, one cycle, decided on registered state:
  - If last_q=1, or req[winner]=0 (message abandoned): ptr <= winner, grant <= 0, state IDLE.
  - Otherwise: state LOAD for the next byte of the same message; grant unchanged.
- Requests arriving mid-message are only recorded in req; they are never granted before the current message ends.
- Fairness: after a message from i, every other pending requester gets a turn before i again.
- A requester dropping req during LOAD before START is treated as abandon:
  - Grant is released without a start pulse.
  - ptr <= winner.
- req_data and req_last are sampled only in LOAD; requesters hold them until req_ack.
- An IDLE->LOAD->START path gives a minimum 2-cycle latency from req to txdStart.

Optional Feature:
- Macro UART_TX_GAP_EN.
- Defined: END goes to state GAP for GAP_CYCLES cycles before LOAD or IDLE.
  - txdStart is held 0 during GAP.
  - Guarantees receiver inter-byte spacing.
- Undefined: no GAP state; END transitions directly as above.

Test Plan:
- Single requester 0 sends 3 bytes 0x31,0x32,0x33 (last on 0x33); transmitter model busy 10 cycles per byte -> three txdStart pulses with matching data, three req_ack[0] pulses, grant 0001 throughout, then 0000 and busy=0.
- req=1111 from IDLE after reset, 1-byte messages each -> grant order 0,1,2,3; second round starts at 0 again; each txdStart is at least 2 cycles after the previous txdBusy fall.
- Requester 2 mid-message (byte 1 of 2) while requester 1 asserts req -> requester 2 completes byte 2 before grant moves to requester 1.
- Transmitter model never raises txdBusy -> timeout_err=1 exactly BUSY_TIMEOUT cycles after txdStart; arbiter still proceeds to the next byte.
- Reset asserted during WAIT_LO with txdBusy held 1 for 5 more cycles -> outputs 0 immediately; first post-reset txdStart only after txdBusy falls.
- With UART_TX_GAP_EN, GAP_CYCLES=4 -> exactly 4 cycles between txdBusy fall and next LOAD; without the macro, 1 cycle.
